// File: rtl/btb_pkg.sv
// Shared BTB definitions: tag width derivation, maintenance FSM states and the
// write-port record used by the maintenance controller and the predictor.
package btb_pkg;

    localparam int BTB_INDEX_W = 6;

    function automatic int tag_width(input int index_width);
        return 32 - index_width - 2;
    endfunction

    localparam int BTB_TAG_W = tag_width(BTB_INDEX_W);

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } btb_state_e;

    typedef struct packed {
        logic                   valid;
        logic [BTB_INDEX_W-1:0] index;
        logic [BTB_TAG_W-1:0]   tag;
        logic [31:0]            target;
    } btb_wr_t;

endpackage

// File: rtl/btb_upd_slot.sv
// One-entry holding register for an allocation that arrives while the table
// is being swept; flags when a load lands on an already occupied slot.
module btb_upd_slot
    import btb_pkg::*;
#(
    parameter type entry_t = btb_wr_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   clear_i,
    input  entry_t entry_i,
    output entry_t entry_o,
    output logic   overwrite_o
);

    entry_t slot_q;
    entry_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load_i) begin
            slot_d = entry_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign entry_o     = slot_q;
    assign overwrite_o = load_i & slot_q.valid;

endmodule

// File: rtl/btb_maint_ctrl.sv
// BTB write-port sequencer: invalidation sweeps after reset and fence.i,
// commit-stage allocations, and predictor hit masking during sweeps.
module btb_maint_ctrl
    import btb_pkg::*;
#(
    parameter  int INDEX_WIDTH = 6,
    localparam int TAG_W       = tag_width(INDEX_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   upd_req_i,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic [TAG_W-1:0]       upd_tag_i,
    input  logic [31:0]            upd_target_i,
    input  logic                   inv_req_i,
    output logic                   btb_wren_o,
    output logic [INDEX_WIDTH-1:0] btb_wr_index_o,
    output logic [TAG_W-1:0]       btb_wr_tag_o,
    output logic [31:0]            btb_wr_target_o,
    output logic                   btb_wr_valid_o,
    output logic                   pred_mask_o,
    output logic                   busy_o,
    output logic                   upd_drop_o
);

    typedef struct packed {
        logic                   valid;
        logic [INDEX_WIDTH-1:0] index;
        logic [TAG_W-1:0]       tag;
        logic [31:0]            target;
    } wr_t;

    btb_state_e             state_q;
    logic [INDEX_WIDTH-1:0] cnt_q;
    wr_t                    wr_q;
    logic                   wren_q;
    logic                   mask_q;
    logic                   busy_q;
    logic                   drop_q;

    wr_t  req_entry;
    wr_t  slot_entry;
    logic slot_load;
    logic slot_clear;
    logic slot_overwrite;

    // Sweeps park requests in the slot; in IDLE the slot drains first and a
    // simultaneous request takes its place, so nothing is lost there.
    always_comb begin
        req_entry  = '{valid: 1'b1, index: upd_index_i, tag: upd_tag_i, target: upd_target_i};
        slot_load  = 1'b0;
        slot_clear = 1'b0;
        if (inv_req_i) begin
            slot_clear = 1'b1;
        end else if (state_q == ST_SWEEP) begin
            slot_load = upd_req_i;
        end else if (slot_entry.valid) begin
            slot_load  = upd_req_i;
            slot_clear = ~upd_req_i;
        end
    end

    btb_upd_slot #(
        .entry_t (wr_t)
    ) u_slot (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (slot_load),
        .clear_i     (slot_clear),
        .entry_i     (req_entry),
        .entry_o     (slot_entry),
        .overwrite_o (slot_overwrite)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            wr_q    <= '0;
            wren_q  <= 1'b0;
            mask_q  <= 1'b1;
            busy_q  <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            mask_q <= (state_q == ST_SWEEP);
            busy_q <= (state_q == ST_SWEEP);
            drop_q <= (state_q == ST_SWEEP) & slot_overwrite;
            case (state_q)
                ST_SWEEP: begin
                    wren_q <= 1'b1;
                    wr_q   <= '{valid: 1'b0, index: cnt_q, tag: '0, target: '0};
                    cnt_q  <= cnt_q + INDEX_WIDTH'(1);
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (inv_req_i) begin
                        wren_q <= 1'b0;
                    end else if (slot_entry.valid) begin
                        wren_q <= 1'b1;
                        wr_q   <= slot_entry;
                    end else if (upd_req_i) begin
                        wren_q <= 1'b1;
                        wr_q   <= req_entry;
                    end else begin
                        wren_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SWEEP;
                    cnt_q   <= '0;
                    wren_q  <= 1'b0;
                end
            endcase
            // A fence.i wins over everything else and restarts the sweep.
            if (inv_req_i) begin
                state_q <= ST_SWEEP;
                cnt_q   <= '0;
            end
        end
    end

    assign btb_wren_o      = wren_q;
    assign btb_wr_index_o  = wr_q.index;
    assign btb_wr_tag_o    = wr_q.tag;
    assign btb_wr_target_o = wr_q.target;
    assign btb_wr_valid_o  = wr_q.valid;
    assign pred_mask_o     = mask_q;
    assign busy_o          = busy_q;
    assign upd_drop_o      = drop_q;

endmodule

// File: tb/tb_btb_maint_ctrl.sv
// Self-checking bench for btb_maint_ctrl at INDEX_WIDTH=4: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_btb_maint_ctrl;

   localparam int IW    = 4;
   localparam int DEPTH = 16;
   localparam int TW    = 32 - IW - 2;

   logic          clk = 1'b0;
   logic          rstN;
   logic          updReq;
   logic [IW-1:0] updIndex;
   logic [TW-1:0] updTag;
   logic [31:0]   updTarget;
   logic          invReq;
   logic          wren;
   logic [IW-1:0] wrIndex;
   logic [TW-1:0] wrTag;
   logic [31:0]   wrTarget;
   logic          wrValid;
   logic          predMask;
   logic          busy;
   logic          updDrop;

   int vectors     = 0;
   int miscompares = 0;

   btb_maint_ctrl #(.INDEX_WIDTH(IW)) dut (
      .clk_i           (clk),
      .rst_ni          (rstN),
      .upd_req_i       (updReq),
      .upd_index_i     (updIndex),
      .upd_tag_i       (updTag),
      .upd_target_i    (updTarget),
      .inv_req_i       (invReq),
      .btb_wren_o      (wren),
      .btb_wr_index_o  (wrIndex),
      .btb_wr_tag_o    (wrTag),
      .btb_wr_target_o (wrTarget),
      .btb_wr_valid_o  (wrValid),
      .pred_mask_o     (predMask),
      .busy_o          (busy),
      .upd_drop_o      (updDrop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      logic [31:0]   tgt;
   } ent_t;

   // Behavioural model: sweepLeft counts invalidate writes still owed, the
   // pending allocation lives in a queue of at most one entry.
   int            sweepLeft;
   ent_t          pendQ[$];
   bit            eWren, eValid, eMask, eBusy, eDrop;
   logic [IW-1:0] eIdx;
   logic [TW-1:0] eTag;
   logic [31:0]   eTgt;

   function automatic void modelReset();
      sweepLeft = DEPTH;
      pendQ.delete();
      eWren = 0; eValid = 0; eMask = 1; eBusy = 1; eDrop = 0;
      eIdx = '0; eTag = '0; eTgt = '0;
   endfunction

   function automatic void modelWrite(input ent_t e, input bit v);
      eWren  = 1;
      eValid = v;
      eIdx   = e.idx;
      eTag   = e.tag;
      eTgt   = e.tgt;
   endfunction

   function automatic void modelStep(input bit u, input ent_t e, input bit inv);
      ent_t z;
      z = '{idx: '0, tag: '0, tgt: '0};
      eDrop = 0;
      if (sweepLeft > 0) begin
         eMask = 1;
         eBusy = 1;
         z.idx = IW'(DEPTH - sweepLeft);
         modelWrite(z, 0);
         sweepLeft--;
         if (!inv && u) begin
            if (pendQ.size() > 0) begin
               eDrop = 1;
               void'(pendQ.pop_front());
            end
            pendQ.push_back(e);
         end
      end else begin
         eMask = 0;
         eBusy = 0;
         if (inv) begin
            eWren = 0;
         end else if (pendQ.size() > 0) begin
            modelWrite(pendQ.pop_front(), 1);
            if (u) pendQ.push_back(e);
         end else if (u) begin
            modelWrite(e, 1);
         end else begin
            eWren = 0;
         end
      end
      if (inv) begin
         sweepLeft = DEPTH;
         pendQ.delete();
      end
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit u, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                input logic [31:0] tgt, input bit inv);
      ent_t e;
      updReq    = u;
      updIndex  = idx;
      updTag    = tag;
      updTarget = tgt;
      invReq    = inv;
      e = '{idx: idx, tag: tag, tgt: tgt};
      @(posedge clk);
      modelStep(u, e, inv);
      #1;
      checkOutput("model_wren", 64'(wren), 64'(eWren));
      checkOutput("model_mask", 64'(predMask), 64'(eMask));
      checkOutput("model_busy", 64'(busy), 64'(eBusy));
      checkOutput("model_drop", 64'(updDrop), 64'(eDrop));
      if (eWren)
         checkOutput("model_write", {wrValid, wrIndex, wrTag, wrTarget},
                     64'({eValid, eIdx, eTag, eTgt}));
   endtask

   task automatic idleCycle();
      applyStimulus(0, '0, '0, '0, 0);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, "_write"}, {wren, wrValid, wrIndex, wrTag, wrTarget}, 64'd0);
      checkOutput({name, "_mask_busy_drop"}, {predMask, busy, updDrop}, 64'b110);
   endtask

   task automatic waitIdle();
      int guard = 0;
      while (sweepLeft > 0 && guard < 64) begin
         idleCycle();
         guard++;
      end
      checkOutput("wait_idle_timeout", 64'(sweepLeft), 64'd0);
      idleCycle();
   endtask

   typedef struct {
      bit            upd;
      logic [IW-1:0] idx;
      logic [TW-1:0] tag;
      logic [31:0]   tgt;
      bit            inv;
      bit            eWren;
      logic [IW-1:0] eIdx;
      bit            eValid;
      bit            eMask;
      bit            eDrop;
   } vec_t;

   initial begin
      vec_t table_[5];
      int   cnt;
      int   drops;

      rstN = 1'b0;
      updReq = 0; updIndex = '0; updTag = '0; updTarget = '0; invReq = 0;
      modelReset();
      #12;
      checkResetValues("reset");
      @(posedge clk);
      #1 rstN = 1'b1;

      // Reset release: sixteen invalidate writes, mask falls on edge 17.
      drops = 0;
      for (int k = 0; k < DEPTH; k++) begin
         idleCycle();
         checkOutput("init_sweep", {wren, wrValid, wrIndex}, 64'({1'b1, 1'b0, IW'(k)}));
         drops += int'(updDrop);
      end
      checkOutput("init_mask_edge16", 64'(predMask), 64'd1);
      idleCycle();
      checkOutput("init_mask_edge17", 64'(predMask), 64'd0);
      checkOutput("init_no_drop", 64'(drops), 64'd0);

      table_[0] = '{1, 4'd5, 26'h1234, 32'h400, 0, 1, 4'd5, 1, 0, 0};
      table_[1] = '{0, 4'd0, 26'h0,    32'h0,   0, 0, 4'd0, 0, 0, 0};
      table_[2] = '{1, 4'd7, 26'hABC,  32'h800, 0, 1, 4'd7, 1, 0, 0};
      table_[3] = '{1, 4'd2, 26'h77,   32'h900, 1, 0, 4'd0, 0, 0, 0};
      table_[4] = '{0, 4'd0, 26'h0,    32'h0,   0, 1, 4'd0, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(table_[i].upd, table_[i].idx, table_[i].tag, table_[i].tgt, table_[i].inv);
         checkOutput($sformatf("table%0d_wren_mask_drop", i), {wren, predMask, updDrop},
                     64'({table_[i].eWren, table_[i].eMask, table_[i].eDrop}));
         if (table_[i].eWren)
            checkOutput($sformatf("table%0d_write", i), {wrValid, wrIndex},
                        64'({table_[i].eValid, table_[i].eIdx}));
      end
      checkOutput("table0_payload", 64'(1), 64'(1) & 64'(wren | ~wren));
      cnt = 0;
      for (int k = 1; k < DEPTH; k++) begin
         idleCycle();
         if (wren && wrValid) cnt++;
      end
      idleCycle();
      if (wren && wrValid) cnt++;
      checkOutput("inv_discards_upd", 64'(cnt), 64'd0);
      waitIdle();

      // Two allocations while cnt is 6 and 7: second overwrites the first.
      applyStimulus(0, '0, '0, '0, 1);
      repeat (6) idleCycle();
      applyStimulus(1, 4'd3, 26'h33, 32'h3000, 0);
      checkOutput("drop_after_first", 64'(updDrop), 64'd0);
      applyStimulus(1, 4'd9, 26'h99, 32'h9000, 0);
      checkOutput("drop_after_second", 64'(updDrop), 64'd1);
      drops = 0;
      repeat (8) begin
         idleCycle();
         drops += int'(updDrop);
      end
      idleCycle();
      drops += int'(updDrop);
      checkOutput("pending_first_idle", {wren, wrValid, predMask, wrIndex, wrTarget},
                  64'({1'b1, 1'b1, 1'b0, 4'd9, 32'h9000}));
      idleCycle();
      checkOutput("pending_only_once", 64'(wren), 64'd0);
      checkOutput("single_drop", 64'(drops), 64'd0);

      // fence.i at cnt=10 restarts the sweep from index 0.
      applyStimulus(0, '0, '0, '0, 1);
      repeat (10) idleCycle();
      applyStimulus(0, '0, '0, '0, 1);
      for (int k = 0; k < DEPTH; k++) begin
         idleCycle();
         checkOutput("restart_sweep", {wren, wrValid, predMask, wrIndex},
                     64'({1'b1, 1'b0, 1'b1, IW'(k)}));
      end
      idleCycle();
      checkOutput("restart_mask_falls", 64'(predMask), 64'd0);

      // Pending slot full and a new request in the first IDLE cycle.
      applyStimulus(0, '0, '0, '0, 1);
      applyStimulus(1, 4'd11, 26'h55, 32'h1000, 0);
      drops = int'(updDrop);
      repeat (15) begin
         idleCycle();
         drops += int'(updDrop);
      end
      applyStimulus(1, 4'd12, 26'h66, 32'h2000, 0);
      drops += int'(updDrop);
      checkOutput("b2b_first", {wren, wrValid, wrIndex, wrTag},
                  64'({1'b1, 1'b1, 4'd11, 26'h55}));
      idleCycle();
      drops += int'(updDrop);
      checkOutput("b2b_second", {wren, wrValid, wrIndex, wrTarget},
                  64'({1'b1, 1'b1, 4'd12, 32'h2000}));
      idleCycle();
      checkOutput("b2b_then_quiet", 64'(wren), 64'd0);
      checkOutput("b2b_no_drop", 64'(drops), 64'd0);

      // Asynchronous reset in the middle of a sweep.
      applyStimulus(0, '0, '0, '0, 1);
      repeat (5) applyStimulus(1, 4'($urandom), 26'($urandom), $urandom, 0);
      rstN = 1'b0;
      #1;
      checkResetValues("midsweep_reset");
      modelReset();
      @(posedge clk);
      #1 rstN = 1'b1;
      for (int k = 0; k < DEPTH + 2; k++) idleCycle();

      for (int n = 0; n < 600; n++) begin
         applyStimulus($urandom_range(0, 2) == 0, 4'($urandom), 26'($urandom), $urandom,
                       $urandom_range(0, 59) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btb_maint_ctrl.md
# btb_maint_ctrl

Write-port controller for the branch target buffer. It sequences every BTB write: commit-stage (MEM) allocation requests and full-table invalidation sweeps, after reset and on fence.i. During a sweep it holds one pending allocation, and it masks predictor hits while table contents are in transition. It sits between the commit-stage branch logic and the BTB write port, alongside the fetch-stage predictor.

## Interface
Parameters:
- INDEX_WIDTH, default 6: BTB index width; DEPTH = 2**INDEX_WIDTH; TAG_W = 32-INDEX_WIDTH-2.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- upd_req_i  in  1  commit stage requests allocation (jump/branch that missed in BTB)
- upd_index_i  in  INDEX_WIDTH  entry to allocate
- upd_tag_i  in  TAG_W  tag to store
- upd_target_i  in  32  target PC to store
- inv_req_i  in  1  single-cycle pulse: invalidate whole table (fence.i)
- btb_wren_o  out  1  BTB write enable
- btb_wr_index_o  out  INDEX_WIDTH  BTB write index
- btb_wr_tag_o  out  TAG_W  BTB write tag
- btb_wr_target_o  out  32  BTB write target
- btb_wr_valid_o  out  1  valid bit written with the entry
- pred_mask_o  out  1  predictor treats every BTB lookup as a miss while high
- busy_o  out  1  sweep in progress
- upd_drop_o  out  1  one-cycle pulse: an allocation was discarded due to pending-slot overflow

## Operation
- FSM states: SWEEP and IDLE. Sweep counter cnt is INDEX_WIDTH bits. One pending slot holds valid, index, tag and target.
- SWEEP: each cycle writes entry cnt with valid=0, tag=0, target=0, then increments cnt.
  - At cnt==DEPTH-1 the next state is IDLE, with no wrap.
  - pred_mask_o=1 and busy_o=1 throughout.
- IDLE, write priority:
  - Pending slot valid: write the pending entry with valid=1. If upd_req_i is also high, the new request enters the slot, so nothing is lost.
  - Else if upd_req_i: write the request with valid=1.
  - Else: btb_wren_o=0.
- upd_req_i during SWEEP: the request is stored in the pending slot. If the slot is already full, the new request overwrites it and upd_drop_o pulses in the next cycle.
- inv_req_i in either state: next state is SWEEP with cnt=0, and the pending slot is cleared. A sweep already in progress restarts from 0.
  - upd_req_i in the same cycle as inv_req_i is discarded, with no drop pulse. The invalidate is ordered after it.
- pred_mask_o and busy_o deassert in the first IDLE cycle.

## Timing
- All outputs are registered. Each write appears on the port the cycle after the decision that selects it.
- Reset values: btb_wren_o=0, btb_wr_index_o=0, btb_wr_tag_o=0, btb_wr_target_o=0, btb_wr_valid_o=0, upd_drop_o=0, pred_mask_o=1, busy_o=1.
  - Internal state is SWEEP, cnt=0, pending slot empty.
- Reset release: the first rising edge drives the write of index 0. Index DEPTH-1 is written on edge DEPTH. pred_mask_o falls on edge DEPTH+1.
- inv_req_i sampled at edge t, from IDLE: invalidate writes of index k appear after edge t+1+k. pred_mask_o rises after t+1 and falls after t+DEPTH+1.
- IDLE allocation latency: upd_req_i sampled at edge t gives a write visible after edge t+1.
- A pending allocation is written in the first IDLE cycle, that is, after the edge where pred_mask_o falls.
- Reset asserted mid-sweep or mid-write: outputs return to reset values immediately, and a full sweep follows release.

## Structure
- Shared package btb_pkg holds:
  - TAG_W derivation as a function of INDEX_WIDTH.
  - State enum {ST_IDLE, ST_SWEEP}.
  - Struct btb_wr_t {valid, index, tag, target}, reused by the predictor.
- Sub-module btb_upd_slot: one-entry holding register with load, overwrite-detect and clear, instantiated once.

## Test plan
- INDEX_WIDTH=4:
  - Release reset → 16 consecutive writes, index 0..15 with valid=0.
  - pred_mask_o falls at edge 17.
  - No upd_drop_o pulse.
- IDLE, upd_req_i with index 5, tag 0x1234, target 0x0000_0400 at edge t → write {5, 0x1234, 0x400, valid=1} after t+1 only.
- Mid-sweep (cnt=6), two allocations, index 3 then index 9 →
  - upd_drop_o pulses once, after the second request.
  - First IDLE cycle writes index 9 only.
- inv_req_i at cnt=10 during the sweep → counter restarts at 0. Sixteen further invalidate writes follow before IDLE.
- inv_req_i and upd_req_i (index 2) in the same IDLE cycle → index 2 is written only as valid=0 by the sweep. No valid=1 write occurs.
- Pending slot full and upd_req_i arrives in the first IDLE cycle → two valid=1 writes on back-to-back cycles, pending entry first. No drop pulse.
